counter_cmd_fsm: RTL and testbench

COUNTER_CMD_FSM -- requirements
Module: counter_cmd_fsm

---
 rtl/counter_cmd_fsm.sv | 195 +++++++++++++++++++
 tb/tb_counter_cmd_fsm.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_cmd_fsm.sv
// counter_cmd_fsm
// Run/stop/clear/mode controller for an up/down counter. Commands come from
// debounced buttons (rising-edge events) and, when the UART_CMD_EN macro is
// defined, from single-letter UART bytes that are also echoed back through a
// one-entry buffer. Without UART_CMD_EN the UART pins are ignored and the
// transmit outputs are tied low.
module counter_cmd_fsm #(
    parameter int CLEAR_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_enable,
    input  logic       i_clear,
    input  logic       i_mode,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       tx_busy,
    output logic       o_enable,
    output logic       o_clear,
    output logic       o_mode,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_CLEAR = 2'b10
    } state_t;

    // Last cycle spent in CLEAR; the counter starts at 0 on entry.
    localparam logic [3:0] LP_CLR_LAST = 4'(CLEAR_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_clr_cnt;
    logic        r_enable;
    logic        r_clear;
    logic        r_mode;

    logic        r_prev_enable;
    logic        r_prev_clear;
    logic        r_prev_mode;

    logic        w_btn_run;
    logic        w_btn_clear;
    logic        w_btn_mode;
    logic        w_rx_run;
    logic        w_rx_clear;
    logic        w_rx_mode;
    logic        w_run_evt;
    logic        w_clear_evt;
    logic        w_mode_evt;

    // Previous button levels; reset high so a button held through reset
    // release is not mistaken for a fresh press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev_enable <= 1'b1;
            r_prev_clear  <= 1'b1;
            r_prev_mode   <= 1'b1;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // always_ff block sees the pre-edge values of the others.
            r_prev_enable <= i_enable;
            r_prev_clear  <= i_clear;
            r_prev_mode   <= i_mode;
        end
    end

    assign w_btn_run   = i_enable & ~r_prev_enable;
    assign w_btn_clear = i_clear  & ~r_prev_clear;
    assign w_btn_mode  = i_mode   & ~r_prev_mode;

`ifdef UART_CMD_EN
    logic       w_rx_cmd;
    logic [7:0] w_rx_upper;
    logic       r_echo_full;
    logic [7:0] r_echo_byte;
    logic       r_tx_start;
    logic [7:0] r_tx_data;

    assign w_rx_run   = rx_done && ((rx_data == 8'h52) || (rx_data == 8'h72));
    assign w_rx_clear = rx_done && ((rx_data == 8'h43) || (rx_data == 8'h63));
    assign w_rx_mode  = rx_done && ((rx_data == 8'h4D) || (rx_data == 8'h6D));
    assign w_rx_cmd   = w_rx_run | w_rx_clear | w_rx_mode;
    // Only letters reach the echo path, so clearing bit 5 upper-cases them.
    assign w_rx_upper = rx_data & 8'hDF;

    // Echo buffer: drain to the transmitter when it is idle; a new command
    // replaces whatever is pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_echo_full <= 1'b0;
            r_echo_byte <= 8'h00;
            r_tx_start  <= 1'b0;
            r_tx_data   <= 8'h00;
        end else begin
            r_tx_start <= 1'b0;
            // The strobe cycle itself is skipped so the transmitter has one
            // cycle to raise tx_busy before another byte could be offered.
            if (r_echo_full && !tx_busy && !r_tx_start) begin
                r_tx_start  <= 1'b1;
                r_tx_data   <= r_echo_byte;
                r_echo_full <= 1'b0;
            end
            // NOTE: the later non-blocking assignment wins, so a command
            // arriving in the drain cycle keeps the buffer full.
            if (w_rx_cmd) begin
                r_echo_byte <= w_rx_upper;
                r_echo_full <= 1'b1;
            end
        end
    end

    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
`else
    // UART pins are deliberately left unobserved in the button-only build.
    logic w_unused;

    assign w_unused   = ^{rx_data, rx_done, tx_busy};
    assign w_rx_run   = 1'b0;
    assign w_rx_clear = 1'b0;
    assign w_rx_mode  = 1'b0;
    assign tx_start   = 1'b0;
    assign tx_data    = 8'h00;
`endif

    // Same-kind events from both sources collapse into one.
    assign w_run_evt   = w_btn_run   | w_rx_run;
    assign w_clear_evt = w_btn_clear | w_rx_clear;
    assign w_mode_evt  = w_btn_mode  | w_rx_mode;

    // Next-state decode; clear outranks run, and CLEAR ignores both.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_next_state = r_state;
        unique case (r_state)
            ST_STOP: begin
                if (w_clear_evt)    w_next_state = ST_CLEAR;
                else if (w_run_evt) w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (w_clear_evt)    w_next_state = ST_CLEAR;
                else if (w_run_evt) w_next_state = ST_STOP;
            end
            ST_CLEAR: begin
                if (r_clr_cnt == LP_CLR_LAST) w_next_state = ST_STOP;
            end
            default: w_next_state = ST_STOP;
        endcase
    end

    // State register with enable/clear registered from the next state so
    // they line up with o_state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_STOP;
            r_enable <= 1'b0;
            r_clear  <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_enable <= (w_next_state == ST_RUN);
            r_clear  <= (w_next_state == ST_CLEAR);
        end
    end

    // Cycles already spent in CLEAR; held at zero in every other state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clr_cnt <= 4'd0;
        end else if (r_state != ST_CLEAR) begin
            r_clr_cnt <= 4'd0;
        end else begin
            r_clr_cnt <= r_clr_cnt + 4'd1;
        end
    end

    // Count direction toggles on every mode event, whatever the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode <= 1'b1;
        end else if (w_mode_evt) begin
            r_mode <= ~r_mode;
        end
    end

    assign o_enable = r_enable;
    assign o_clear  = r_clear;
    assign o_mode   = r_mode;
    assign o_state  = r_state;

endmodule

// File: tb/tb_counter_cmd_fsm.sv
// Testbench for counter_cmd_fsm. Stimulus pushes expected output snapshots
// and echo bytes into queues; a monitor pops them whenever the DUT outputs
// change or tx_start pulses. Expectations follow UART_CMD_EN if defined.
module tb_counter_cmd_fsm;

`ifdef UART_CMD_EN
    localparam bit UART = 1'b1;
`else
    localparam bit UART = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       i_enable;
    logic       i_clear;
    logic       i_mode;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_busy;
    logic       o_enable;
    logic       o_clear;
    logic       o_mode;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [1:0] o_state;

    counter_cmd_fsm #(.CLEAR_CYCLES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_enable (i_enable),
        .i_clear  (i_clear),
        .i_mode   (i_mode),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .tx_busy  (tx_busy),
        .o_enable (o_enable),
        .o_clear  (o_clear),
        .o_mode   (o_mode),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .o_state  (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Snapshot order: {o_enable, o_clear, o_mode, o_state}
    typedef struct {
        logic [4:0] val;
        int         deadline;  // latest cycle the change may appear, -1 = none
        int         gap;       // exact cycles since previous change, -1 = none
        string      name;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] tx_q[$];

    int n_checks   = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int last_chg   = 0;
    int n_tx_seen  = 0;
    int n_tx_exp   = 0;
    logic m        = 1'b1;   // model of o_mode
    logic [4:0] prev = 5'b00100;
    logic [4:0] cur;
    exp_t       e;
    logic [7:0] tb;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input string name, input logic en, input logic clr,
                        input logic md, input logic [1:0] st, input int dl, input int gap);
        exp_t x;
        x.val = {en, clr, md, st};
        x.deadline = dl;
        x.gap = gap;
        x.name = name;
        exp_q.push_back(x);
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_q.push_back(b);
        n_tx_exp++;
    endtask

    // Presents one byte with a single-cycle rx_done.
    task automatic uart_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cur = {o_enable, o_clear, o_mode, o_state};
        if (rst && cur !== prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_change", 32'(cur), 32'(prev));
            end else begin
                e = exp_q.pop_front();
                check(e.name, 32'(cur), 32'(e.val));
                if (e.deadline >= 0) check({e.name, "_latency"}, 32'(cyc <= e.deadline), 32'd1);
                if (e.gap >= 0) check({e.name, "_duration"}, 32'(cyc - last_chg), 32'(e.gap));
            end
            last_chg = cyc;
        end
        prev = cur;
        if (rst && tx_start) begin
            n_tx_seen++;
            check("tx_start_while_idle", 32'(tx_busy), 32'd0);
            if (tx_q.size() == 0) begin
                check("unexpected_tx", 32'(tx_data), 32'hFFFF_FFFF);
            end else begin
                tb = tx_q.pop_front();
                check("tx_echo", 32'(tx_data), 32'(tb));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        int tx_before;
        rst = 1'b1; i_enable = 1'b1; i_clear = 1'b0; i_mode = 1'b0;
        rx_data = 8'h00; rx_done = 1'b0; tx_busy = 1'b0;
        #2 rst = 1'b0;

        // Reset values, with i_enable held high through release.
        tick(3);
        check("reset_outputs", 32'({o_enable, o_clear, o_mode, o_state, tx_start}), 32'b001000);
        check("reset_tx_data", 32'(tx_data), 32'h00);
        rst = 1'b1;
        tick(3);
        i_enable = 1'b0;
        tick(3);

        // Run press held 3 cycles: one transition to RUN only.
        c = cyc;
        i_enable = 1'b1;
        push("run_start", 1'b1, 1'b0, m, 2'b01, c + 2, -1);
        tick(3);
        i_enable = 1'b0;
        tick(3);

        // Clear button with 'r' in the same cycle: clear wins, 2-cycle CLEAR.
        // A run press during CLEAR is discarded.
        c = cyc;
        i_clear = 1'b1;
        rx_data = 8'h72;
        rx_done = 1'b1;
        push("clear_enter", 1'b0, 1'b1, m, 2'b10, c + 2, -1);
        push("clear_exit", 1'b0, 1'b0, m, 2'b00, -1, 2);
        if (UART) push_tx(8'h52);
        tick();
        rx_done = 1'b0;
        rx_data = 8'h00;
        i_enable = 1'b1;
        tick();
        i_enable = 1'b0;
        i_clear = 1'b0;
        tick(5);

        // Mode button and 'm' together: a single toggle.
        c = cyc;
        i_mode = 1'b1;
        rx_data = 8'h6D;
        rx_done = 1'b1;
        m = ~m;
        push("mode_merge", 1'b0, 1'b0, m, 2'b00, c + 2, -1);
        if (UART) push_tx(8'h4D);
        tick();
        rx_done = 1'b0;
        rx_data = 8'h00;
        tick(2);
        i_mode = 1'b0;
        tick(4);

        // Run and clear buttons together from STOP: clear only.
        c = cyc;
        i_enable = 1'b1;
        i_clear = 1'b1;
        push("clear_only_enter", 1'b0, 1'b1, m, 2'b10, c + 2, -1);
        push("clear_only_exit", 1'b0, 1'b0, m, 2'b00, -1, 2);
        tick(5);
        i_enable = 1'b0;
        i_clear = 1'b0;
        tick(3);

        // Echo held while tx_busy; 'M' overwrites pending 'C'.
        tx_busy = 1'b1;
        tx_before = n_tx_seen;
        c = cyc;
        if (UART) begin
            push("uart_clear_enter", 1'b0, 1'b1, m, 2'b10, c + 2, -1);
            push("uart_clear_exit", 1'b0, 1'b0, m, 2'b00, -1, 2);
        end
        uart_byte(8'h63);
        tick(5);
        c = cyc;
        if (UART) begin
            m = ~m;
            push("uart_mode", 1'b0, 1'b0, m, 2'b00, c + 2, -1);
        end
        uart_byte(8'h4D);
        tick(4);
        check("tx_held_while_busy", 32'(n_tx_seen), 32'(tx_before));
        if (UART) push_tx(8'h4D);
        tx_busy = 1'b0;
        tick(5);

        // Unknown byte: nothing happens.
        tx_before = n_tx_seen;
        uart_byte(8'h41);
        tick(5);
        check("ignored_byte_no_tx", 32'(n_tx_seen), 32'(tx_before));

        // Reset during the first CLEAR cycle aborts the clear.
        c = cyc;
        i_clear = 1'b1;
        push("clear_before_reset", 1'b0, 1'b1, m, 2'b10, c + 2, -1);
        tick();
        i_clear = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        m = 1'b1;
        #1;
        check("async_reset_outputs", 32'({o_enable, o_clear, o_mode, o_state, tx_start}), 32'b001000);
        check("async_reset_tx_data", 32'(tx_data), 32'h00);
        tick(2);
        rst = 1'b1;
        tick(6);
        check("post_reset_state_mode", 32'({o_state, o_mode}), 32'b001);

        tick(5);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("tx_queue_drained", 32'(tx_q.size()), 32'd0);
        check("tx_count", 32'(n_tx_seen), 32'(n_tx_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
